stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Run-control front end for the three-digit BCD stopwatch. Debounces the raw Start/Stop and Clear push-buttons and runs an IDLE/RUN/PAUSE state machine. A clock prescaler generates the single-cycle 0.1 s count-enable pulse that drives the tenths-digit BCD counter. Sits directly upstream of the BCD counter chain: its Tick output feeds the first counter's Enable, and its nClear output is ANDed with nReset to zero the counter chain.

## Interface
- DIV, 5_000_000: clock cycles per Tick (50 MHz → 0.1 s); must be ≥ 2.
- DEBOUNCE, 500_000: consecutive stable cycles needed to accept a button level change (10 ms); must be ≥ 1.
- Clk  in  1  system clock; all logic is on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- nBtn_StartStop  in  1  raw Start/Stop button, active-low, asynchronous to Clk.
- nBtn_Clear  in  1  raw Clear button, active-low, asynchronous to Clk.
- Tick  out  1  one-cycle count-enable pulse, issued only in RUN.
- nClear  out  1  active-low, one-cycle clear pulse to the counter chain.
- Running  out  1  high while in RUN.

## Operation
- Reset values:
  - Tick = 0, nClear = 1, Running = 0.
  - State = IDLE, prescaler = 0.
  - Both debouncers are in the released state (stable = 1, counter = 0).
- Debounce, per button:
  - Raw input passes through a 2-flop synchronizer.
  - The counter increments while the synchronized level ≠ stable level, and clears otherwise.
  - When the counter reaches DEBOUNCE, stable takes the synchronized level and the counter clears.
  - A stable 1→0 transition emits a one-cycle press event. Release (0→1) emits nothing.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start/stop event → RUN.
  - RUN + start/stop event → PAUSE.
  - PAUSE + start/stop event → RUN.
  - PAUSE + clear event → IDLE, with nClear pulsed low for 1 cycle.
  - IDLE + clear event → stays IDLE, nClear still pulsed (idempotent clear).
  - RUN + clear event: ignored.
  - Simultaneous events in PAUSE: clear wins → IDLE; the start/stop event is dropped.
  - Simultaneous events in RUN: start/stop is processed → PAUSE; clear is ignored.
- Prescaler, 0..DIV-1, width $clog2(DIV):
  - In RUN: increments each cycle. When it reaches DIV-1, Tick = 1 in the following cycle and the prescaler wraps to 0.
  - In PAUSE: holds its value, so the partial interval is preserved across resume.
  - On entry to IDLE: forced to 0.
- Tick is never asserted outside RUN. On the RUN→PAUSE transition cycle, no Tick is issued even if the prescaler is at DIV-1.
- A button held through reset release produces a press event after debounce. This is legitimate behaviour.

## Timing
- Raw press stable from edge k → press event at edge k+2+DEBOUNCE (2 synchronizer stages plus DEBOUNCE cycles).
- FSM state, Running and nClear update at the edge after the event.
- In continuous RUN, Tick has period exactly DIV cycles. The first Tick comes DIV cycles after Running rises from IDLE.
- nReset is asynchronous: all outputs go to their reset values immediately, including mid-RUN or mid-debounce. Release is synchronous to the design's usual reset synchronizer.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package stopwatch_pkg:
  - FSM state encoding (IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2).
  - Default DIV and DEBOUNCE constants.
- Sub-module btn_debounce:
  - Contains the synchronizer, stable register, counter and press-event output.
  - Parameter DEBOUNCE.
  - Instantiated twice, once per button.
- The top level holds the FSM, the prescaler and the output registers.

## Test plan
All scenarios use DIV = 10 and DEBOUNCE = 4.

1. Reset, then 100 idle cycles → Tick = 0, Running = 0, nClear = 1 throughout.
2. Hold nBtn_StartStop low for 12 cycles from edge 0 → event at edge 6, Running = 1 at edge 7, Ticks at edges 17, 27, 37, … each exactly 1 cycle wide.
3. Bounce: three 3-cycle low pulses separated by 2 high cycles → no event, Running stays 0.
4. Run 25 cycles (prescaler = 5), press Start/Stop → PAUSE, no Tick while paused. Press again → first Tick 5 cycles after Running re-asserts, then period 10.
5. Clear event in RUN → ignored, nClear = 1. Clear event in PAUSE → nClear low for exactly 1 cycle, state IDLE, prescaler = 0. Clear and Start/Stop events on the same edge in PAUSE → IDLE.
6. Assert nReset mid-RUN (and mid-debounce) → Tick = 0, Running = 0, nClear = 1 immediately. After release, no event fires until a fresh press has been stable for DEBOUNCE cycles.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch run-control block: FSM state
// encoding and default timing constants for a 50 MHz system clock.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    // 50 MHz clock: 0.1 s per tick, 10 ms of contact stability per button.
    localparam int DIV_DEFAULT      = 5_000_000;
    localparam int DEBOUNCE_DEFAULT = 500_000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// one-cycle press event on each accepted high-to-low (press) transition.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic nbtn,
    output logic press
);

    localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic [CW-1:0] cnt_r;
    logic          press_r;

    // Bring the asynchronous button level into the clock domain; released = 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= nbtn;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after it has differed from the stable level long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= 1'b1;
            cnt_r    <= '0;
            press_r  <= 1'b0;
        end else if (sync2_r != stable_r) begin
            if (cnt_r == CNT_MAX) begin
                stable_r <= sync2_r;
                cnt_r    <= '0;
                press_r  <= ~sync2_r;
            end else begin
                cnt_r    <= cnt_r + CW'(1);
                press_r  <= 1'b0;
            end
        end else begin
            cnt_r   <= '0;
            press_r <= 1'b0;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run control: debounced Start/Stop and Clear buttons drive an
// IDLE/RUN/PAUSE machine; a prescaler issues the 0.1 s count-enable Tick
// and a one-cycle active-low clear for the downstream BCD counter chain.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DIV      = DIV_DEFAULT,
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input  logic Clk,
    input  logic nReset,
    input  logic nBtn_StartStop,
    input  logic nBtn_Clear,
    output logic Tick,
    output logic nClear,
    output logic Running
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    logic          ss_ev_s;
    logic          clr_ev_s;
    sw_state_t     state_r;
    sw_state_t     state_nx_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nx_s;
    logic          tick_nx_s;
    logic          nclear_nx_s;
    logic          tick_r;
    logic          nclear_r;
    logic          running_r;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_startstop (
        .clk   (Clk),
        .rst_n (nReset),
        .nbtn  (nBtn_StartStop),
        .press (ss_ev_s)
    );

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_clear (
        .clk   (Clk),
        .rst_n (nReset),
        .nbtn  (nBtn_Clear),
        .press (clr_ev_s)
    );

    // Next state, prescaler and output values from the current state and button events.
    always_comb begin
        state_nx_s  = state_r;
        presc_nx_s  = presc_r;
        tick_nx_s   = 1'b0;
        nclear_nx_s = 1'b1;
        case (state_r)
            ST_IDLE: begin
                presc_nx_s = '0;
                if (clr_ev_s) begin
                    nclear_nx_s = 1'b0;
                end else if (ss_ev_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Pausing freezes the prescaler and suppresses any Tick due now.
                if (ss_ev_s) begin
                    state_nx_s = ST_PAUSE;
                end else if (presc_r == PRESC_MAX) begin
                    presc_nx_s = '0;
                    tick_nx_s  = 1'b1;
                end else begin
                    presc_nx_s = presc_r + PW'(1);
                end
            end
            ST_PAUSE: begin
                // Clear takes priority over a coincident start/stop press.
                if (clr_ev_s) begin
                    state_nx_s  = ST_IDLE;
                    presc_nx_s  = '0;
                    nclear_nx_s = 1'b0;
                end else if (ss_ev_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_PAUSE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                presc_nx_s = '0;
            end
        endcase
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_r   <= ST_IDLE;
            presc_r   <= '0;
            tick_r    <= 1'b0;
            nclear_r  <= 1'b1;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            presc_r   <= presc_nx_s;
            tick_r    <= tick_nx_s;
            nclear_r  <= nclear_nx_s;
            running_r <= (state_nx_s == ST_RUN);
        end
    end

    assign Tick    = tick_r;
    assign nClear  = nclear_r;
    assign Running = running_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DIV = 10, DEBOUNCE = 4. A behavioural model
// (sample-history windows for the buttons, an accumulated run-cycle count
// for the tick) is checked against the outputs on every falling edge, and
// directed scenarios pin key cycles with hand-computed literals.
module tb_stopwatch_ctrl;

    localparam int DV = 10;
    localparam int DB = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    logic nss = 1'b1;
    logic ncl = 1'b1;
    logic Tick, nClear, Running;

    int vec_n = 0;
    int err_n = 0;

    // Model state
    logic [DB+2:0] h_ss = '1;
    logic [DB+2:0] h_cl = '1;
    bit st_ss = 1'b1, st_cl = 1'b1;
    bit pend_ss = 1'b0, pend_cl = 1'b0;
    int mode = M_IDLE;
    int acc = 0;
    bit m_tick = 1'b0, m_nclr = 1'b1, m_run = 1'b0;

    stopwatch_ctrl #(.DIV(DV), .DEBOUNCE(DB)) dut (
        .Clk            (clk),
        .nReset         (nReset),
        .nBtn_StartStop (nss),
        .nBtn_Clear     (ncl),
        .Tick           (Tick),
        .nClear         (nClear),
        .Running        (Running)
    );

    always #5 clk = ~clk;

    // A button level is accepted when the DB+1 samples taken 2..DB+2 edges ago all differ from it.
    function automatic bit flips(input logic [DB+2:0] h, input bit s);
        logic [DB:0] w;
        w = h[DB+2:2];
        return s ? (w == '0) : (w == '1);
    endfunction

    task automatic chk(input string nm, input logic got, input logic exp);
        vec_n++;
        if (got !== exp) begin
            err_n++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural model, advanced on every rising edge or reset assertion.
    initial begin
        forever begin
            @(posedge clk or negedge nReset);
            if (!nReset) begin
                h_ss = '1; h_cl = '1; st_ss = 1'b1; st_cl = 1'b1;
                pend_ss = 1'b0; pend_cl = 1'b0;
                mode = M_IDLE; acc = 0;
                m_tick = 1'b0; m_nclr = 1'b1; m_run = 1'b0;
            end else begin
                m_tick = 1'b0;
                m_nclr = 1'b1;
                if (mode == M_IDLE) begin
                    if (pend_cl) m_nclr = 1'b0;
                    else if (pend_ss) begin mode = M_RUN; acc = 0; end
                end else if (mode == M_RUN) begin
                    if (pend_ss) mode = M_PAUSE;
                    else begin
                        acc++;
                        if (acc % DV == 0) m_tick = 1'b1;
                    end
                end else begin
                    if (pend_cl) begin mode = M_IDLE; acc = 0; m_nclr = 1'b0; end
                    else if (pend_ss) mode = M_RUN;
                end
                m_run = (mode == M_RUN);
                h_ss = {h_ss[DB+1:0], nss};
                h_cl = {h_cl[DB+1:0], ncl};
                pend_ss = 1'b0;
                pend_cl = 1'b0;
                if (flips(h_ss, st_ss)) begin st_ss = ~st_ss; pend_ss = ~st_ss; end
                if (flips(h_cl, st_cl)) begin st_cl = ~st_cl; pend_cl = ~st_cl; end
            end
        end
    end

    // Compare the outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("tick", Tick, m_tick);
            chk("nclear", nClear, m_nclr);
            chk("running", Running, m_run);
        end
    end

    // Directed scenarios; comments give edge numbers relative to the press start.
    initial begin
        // Reset, then 100 idle cycles
        repeat (3) @(negedge clk);
        nReset = 1'b1;
        edges(100);
        chk("idle_running", Running, 1'b0);
        chk("idle_nclear", nClear, 1'b1);

        // Bounce: three 3-cycle low pulses, no event
        repeat (3) begin
            nss = 1'b0; edges(3);
            nss = 1'b1; edges(2);
        end
        edges(20);
        chk("bounce_running", Running, 1'b0);

        // Start: low sampled from edge 0
        nss = 1'b0;
        edges(7);  chk("start_e6_running", Running, 1'b0);
        edges(1);  chk("start_e7_running", Running, 1'b1);
        edges(4);  nss = 1'b1;                              // after edge 11
        edges(5);  chk("tick_e16", Tick, 1'b0);
        edges(1);  chk("tick_e17", Tick, 1'b1);
        edges(1);  chk("tick_e18", Tick, 1'b0);
        edges(9);  chk("tick_e27", Tick, 1'b1);

        // Pause with prescaler at 5, then resume
        edges(8);  nss = 1'b0;                              // after edge 35
        edges(6);  nss = 1'b1;                              // after edge 41
        edges(1);  chk("pause_e42_running", Running, 1'b1);
        edges(1);  chk("pause_e43_running", Running, 1'b0);
        edges(20); nss = 1'b0;                              // after edge 63
        edges(6);  nss = 1'b1;
        edges(1);  chk("resume_e70_running", Running, 1'b0);
        edges(1);  chk("resume_e71_running", Running, 1'b1);
        edges(4);  chk("resume_e75_tick", Tick, 1'b0);
        edges(1);  chk("resume_e76_tick", Tick, 1'b1);
        edges(10); chk("resume_e86_tick", Tick, 1'b1);

        // Clear in RUN is ignored
        ncl = 1'b0;
        edges(6);  ncl = 1'b1;                              // after edge 92
        edges(2);  chk("runclr_nclear", nClear, 1'b1);
        chk("runclr_running", Running, 1'b1);

        // Pause, then clear
        edges(2);  nss = 1'b0;                              // after edge 96
        edges(6);  nss = 1'b1;
        edges(4);  chk("pause2_running", Running, 1'b0);    // after edge 106
        edges(4);  ncl = 1'b0;                              // after edge 110
        edges(6);  ncl = 1'b1;
        edges(1);  chk("clr_e117_nclear", nClear, 1'b1);
        edges(1);  chk("clr_e118_nclear", nClear, 1'b0);
        chk("clr_e118_running", Running, 1'b0);
        edges(1);  chk("clr_e119_nclear", nClear, 1'b1);

        // Restart from IDLE: prescaler restarted from 0
        edges(6);  nss = 1'b0;                              // after edge 125
        edges(6);  nss = 1'b1;
        edges(2);  chk("restart_running", Running, 1'b1);   // after edge 133
        edges(9);  chk("restart_tick_e142", Tick, 1'b0);
        edges(1);  chk("restart_tick_e143", Tick, 1'b1);

        // Pause, then simultaneous clear + start/stop
        edges(2);  nss = 1'b0;                              // after edge 145
        edges(6);  nss = 1'b1;
        edges(8);  nss = 1'b0; ncl = 1'b0;                  // after edge 159
        edges(6);  nss = 1'b1; ncl = 1'b1;
        edges(2);  chk("simul_running", Running, 1'b0);     // after edge 167
        chk("simul_nclear", nClear, 1'b0);
        edges(12); chk("simul_late_running", Running, 1'b0);

        // Asynchronous reset mid-RUN and mid-debounce
        edges(1);  nss = 1'b0;
        edges(6);  nss = 1'b1;
        edges(15); ncl = 1'b0;
        edges(2);
        chk("prerst_running", Running, 1'b1);
        #2 nReset = 1'b0;
        #1;
        chk("rst_tick", Tick, 1'b0);
        chk("rst_running", Running, 1'b0);
        chk("rst_nclear", nClear, 1'b1);
        ncl = 1'b1;
        repeat (3) @(negedge clk);
        nReset = 1'b1;
        edges(1);
        nss = 1'b0; edges(3);
        nss = 1'b1; edges(10);
        chk("postrst_partial_running", Running, 1'b0);
        nss = 1'b0;
        edges(6);  nss = 1'b1;
        edges(1);  chk("postrst_e7_running", Running, 1'b0);
        edges(1);  chk("postrst_e8_running", Running, 1'b1);
        edges(5);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule
